afifo_read_arbiter: RTL and testbench

Read-domain round-robin scheduler that drains up to NUM_CH asynchronous FIFO read ports into one registered valid/ready stream. It sits on the read_clk side, directly on each FIFO's read_en/empty/read_data (show-ahead) ports. It grants one channel at a time for a burst of up to MAX_BURST words, then rotates. It tags each output word with its source channel and marks burst ends.

---
 rtl/afifo_read_arbiter_if.sv | 33 +++
 rtl/afifo_read_arbiter.sv | 138 +++++++++++++
 tb/tb_afifo_read_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : afifo_read_arbiter_if
// Brief    : FIFO read-port bundle and tagged output stream of the read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface afifo_read_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       fifo_empty;
    logic [NUM_CH*WIDTH-1:0] fifo_read_data;
    logic [NUM_CH-1:0]       fifo_read_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_channel;
    logic                    out_last;

    modport master (
        input  ch_enable, fifo_empty, fifo_read_data, out_ready,
        output fifo_read_en, out_valid, out_data, out_channel, out_last
    );

    modport slave (
        output ch_enable, fifo_empty, fifo_read_data, out_ready,
        input  fifo_read_en, out_valid, out_data, out_channel, out_last
    );
endinterface
`default_nettype wire

// File: rtl/afifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : afifo_read_arbiter
// Brief    : Round-robin burst scheduler draining show-ahead FIFO read ports
//            into one registered, channel-tagged valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module afifo_read_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 4
) (
    input  wire                  read_clk,
    input  wire                  reset_rsync,
    afifo_read_arbiter_if.master arb_io
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            state_q,       state_d;
    logic [CH_W-1:0]   grant_q,       grant_d;
    logic [CH_W-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic              out_valid_q,   out_valid_d;
    logic [WIDTH-1:0]  out_data_q,    out_data_d;
    logic [CH_W-1:0]   out_channel_q, out_channel_d;
    logic              out_last_q,    out_last_d;

    logic [NUM_CH-1:0] w_req;
    logic              w_space;
    logic              w_pop;
    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    logic [WIDTH-1:0]  w_ch_data [NUM_CH];

    assign w_req   = arb_io.ch_enable & ~arb_io.fifo_empty;
    assign w_space = !out_valid_q || arb_io.out_ready;

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            assign w_ch_data[gc]          = arb_io.fifo_read_data[gc*WIDTH +: WIDTH];
            assign arb_io.fifo_read_en[gc] = w_pop && (grant_q == CH_W'(gc));
        end
    endgenerate

    // First requester at or after rr_ptr; the index wraps because NUM_CH is a power of two.
    always_comb begin
        w_found = 1'b0;
        w_pick  = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_req[rr_ptr_q + CH_W'(i)]) begin
                w_found = 1'b1;
                w_pick  = rr_ptr_q + CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_last_d    = out_last_q;
        w_pop         = 1'b0;

        if (out_valid_q && arb_io.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    count_d = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_req[grant_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q + CH_W'(1);
                end else if (w_space) begin
                    w_pop         = 1'b1;
                    out_valid_d   = 1'b1;
                    out_data_d    = w_ch_data[grant_q];
                    out_channel_d = grant_q;
                    out_last_d    = (count_q == LAST_BEAT);
                    if (count_q == LAST_BEAT) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q + CH_W'(1);
                        count_d  = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge read_clk or posedge reset_rsync) begin
        if (reset_rsync) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_last_q    <= out_last_d;
        end
    end

    assign arb_io.out_valid   = out_valid_q;
    assign arb_io.out_data    = out_data_q;
    assign arb_io.out_channel = out_channel_q;
    assign arb_io.out_last    = out_last_q;
endmodule
`default_nettype wire

// File: tb/tb_afifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_afifo_read_arbiter
// Brief    : Queue-modelled FIFOs feeding afifo_read_arbiter; scoreboarded output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afifo_read_arbiter;
    localparam int WIDTH     = 32;
    localparam int NUM_CH    = 4;
    localparam int MAX_BURST = 4;
    localparam int CH_W      = 2;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
        logic             last;
        int               cyc;
    } word_t;

    logic read_clk    = 1'b0;
    logic reset_rsync = 1'b1;

    afifo_read_arbiter_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

    afifo_read_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_CH    (NUM_CH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .read_clk    (read_clk),
        .reset_rsync (reset_rsync),
        .arb_io      (bus)
    );

    always #5 read_clk = ~read_clk;

    logic [WIDTH-1:0]  fq     [NUM_CH][$];
    logic [WIDTH-1:0]  exp_ch [NUM_CH][$];
    logic [NUM_CH-1:0] force_empty = '0;
    word_t             got_q[$];
    word_t             exp_q[$];
    int                cyc    = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    function automatic logic [WIDTH-1:0] mk(input int c, input int tag, input int i);
        return {8'(c), 8'(tag), 16'(i)};
    endfunction

    function automatic word_t ew(input int c, input logic [WIDTH-1:0] d, input logic l);
        word_t w;
        w.ch = CH_W'(c); w.data = d; w.last = l; w.cyc = 0;
        return w;
    endfunction

    task automatic refresh();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.fifo_empty[c] = (fq[c].size() == 0) || force_empty[c];
            bus.fifo_read_data[c*WIDTH +: WIDTH] = (fq[c].size() != 0) ? fq[c][0] : '0;
        end
    endtask

    // Samples the pre-edge handshake at negedge, then pops the modelled FIFOs after the edge.
    task automatic tick();
        logic [NUM_CH-1:0] en;
        logic              acc;
        word_t             w;
        @(negedge read_clk);
        en     = bus.fifo_read_en;
        acc    = bus.out_valid && bus.out_ready && !reset_rsync;
        w.ch   = bus.out_channel;
        w.data = bus.out_data;
        w.last = bus.out_last;
        @(posedge read_clk);
        cyc++;
        w.cyc = cyc;
        #1;
        for (int c = 0; c < NUM_CH; c++)
            if (en[c] && fq[c].size() != 0) void'(fq[c].pop_front());
        if (acc) got_q.push_back(w);
        refresh();
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic apply_reset();
        reset_rsync = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            fq[c].delete();
            exp_ch[c].delete();
        end
        force_empty    = '0;
        bus.ch_enable  = '1;
        bus.out_ready  = 1'b1;
        refresh();
        tick();
        tick();
        reset_rsync = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_rsync = 1'b1;
        fq[0].push_back(mk(0, 1, 0));
        refresh();
        tick();
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_tests++;
        if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0", bus.out_data); end
        n_tests++;
        if (bus.out_channel !== '0) begin n_fail++; $display("FAIL reset_out_channel: got %0d, expected 0", bus.out_channel); end
        n_tests++;
        if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b, expected 0", bus.out_last); end
        n_tests++;
        if (bus.fifo_read_en !== '0) begin n_fail++; $display("FAIL reset_read_en: got %b, expected 0", bus.fifo_read_en); end
    endtask

    task automatic test_single_channel();
        bit    ok;
        int    load_cyc;
        word_t g, e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            fq[2].push_back(mk(2, 2, i));
            exp_q.push_back(ew(2, mk(2, 2, i), 1'b0));
        end
        refresh();
        load_cyc = cyc;
        wait_got(3, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL single_timeout: got %0d words, expected 3", got_q.size());
        end else begin
            n_tests++;
            if (got_q[0].cyc != load_cyc + 3) begin
                n_fail++; $display("FAIL single_latency: first word at +%0d, expected +3", got_q[0].cyc - load_cyc);
            end
            n_tests++;
            if (got_q[1].cyc != got_q[0].cyc + 1 || got_q[2].cyc != got_q[1].cyc + 1) begin
                n_fail++; $display("FAIL single_back_to_back: cycles %0d %0d %0d, expected consecutive",
                                   got_q[0].cyc, got_q[1].cyc, got_q[2].cyc);
            end
        end
        // Channel 3 must win over channel 0 because the pointer moved past channel 2.
        fq[0].push_back(mk(0, 3, 0));
        fq[3].push_back(mk(3, 3, 0));
        exp_q.push_back(ew(3, mk(3, 3, 0), 1'b0));
        exp_q.push_back(ew(0, mk(0, 3, 0), 1'b0));
        refresh();
        wait_got(5, 20, ok);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL single_word: no output, expected ch%0d %h", e.ch, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch !== e.ch || g.data !== e.data || g.last !== e.last) begin
                    n_fail++; $display("FAIL single_word: got ch%0d %h last %b, expected ch%0d %h last %b",
                                       g.ch, g.data, g.last, e.ch, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        bit    ok;
        word_t g, e;
        apply_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 8; i++) fq[c].push_back(mk(c, 4, i));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < MAX_BURST; k++)
                    exp_q.push_back(ew(c, mk(c, 4, r*MAX_BURST + k), k == MAX_BURST-1));
        refresh();
        wait_got(32, 200, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rr_timeout: got %0d words, expected 32", got_q.size());
        end else if (got_q[31].cyc - got_q[0].cyc != 38) begin
            n_fail++; $display("FAIL rr_throughput: span %0d cycles, expected 38", got_q[31].cyc - got_q[0].cyc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL rr_word: no output, expected ch%0d %h", e.ch, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch !== e.ch || g.data !== e.data || g.last !== e.last) begin
                    n_fail++; $display("FAIL rr_word: got ch%0d %h last %b, expected ch%0d %h last %b",
                                       g.ch, g.data, g.last, e.ch, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit    ok;
        word_t g, e;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            fq[0].push_back(mk(0, 5, i));
            exp_q.push_back(ew(0, mk(0, 5, i), (i % MAX_BURST) == MAX_BURST-1));
        end
        refresh();
        wait_got(2, 20, ok);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mk(0, 5, 2) || bus.out_channel !== 2'd0
                || bus.fifo_read_en !== '0) begin
                n_fail++; $display("FAIL bp_hold: got valid %b data %h ch%0d en %b, expected 1 %h ch0 en 0000",
                                   bus.out_valid, bus.out_data, bus.out_channel, bus.fifo_read_en, mk(0, 5, 2));
            end
        end
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d words, expected 2", got_q.size()); end
        bus.out_ready = 1'b1;
        wait_got(8, 60, ok);
        repeat (5) tick();
        n_tests++;
        if (got_q.size() != 8 || fq[0].size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d words / %0d left, expected 8 / 0", got_q.size(), fq[0].size());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL bp_word: no output, expected ch%0d %h", e.ch, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch !== e.ch || g.data !== e.data || g.last !== e.last) begin
                    n_fail++; $display("FAIL bp_word: got ch%0d %h last %b, expected ch%0d %h last %b",
                                       g.ch, g.data, g.last, e.ch, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_enable_mask();
        bit    ok;
        word_t g, e;
        apply_reset();
        bus.ch_enable = 4'b1010;
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 8; i++) fq[c].push_back(mk(c, 6, i));
        for (int i = 0; i < 4; i++) exp_q.push_back(ew(1, mk(1, 6, i), i == 3));
        for (int i = 0; i < 2; i++) exp_q.push_back(ew(3, mk(3, 6, i), 1'b0));
        for (int i = 4; i < 8; i++) exp_q.push_back(ew(1, mk(1, 6, i), i == 7));
        refresh();
        wait_got(5, 40, ok);
        bus.ch_enable = 4'b0010;
        wait_got(10, 60, ok);
        repeat (6) tick();
        n_tests++;
        if (got_q.size() != 10 || fq[0].size() != 8 || fq[1].size() != 0 || fq[2].size() != 8 || fq[3].size() != 6) begin
            n_fail++; $display("FAIL mask_pops: got %0d words, left %0d/%0d/%0d/%0d, expected 10, 8/0/8/6",
                               got_q.size(), fq[0].size(), fq[1].size(), fq[2].size(), fq[3].size());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL mask_word: no output, expected ch%0d %h", e.ch, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch !== e.ch || g.data !== e.data || g.last !== e.last) begin
                    n_fail++; $display("FAIL mask_word: got ch%0d %h last %b, expected ch%0d %h last %b",
                                       g.ch, g.data, g.last, e.ch, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit    ok;
        int    k;
        word_t g, e;
        apply_reset();
        for (int i = 0; i < 4; i++) fq[3].push_back(mk(3, 7, i));
        refresh();
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin tick(); k++; end
        for (int i = 0; i < 2; i++) fq[1].push_back(mk(1, 7, i));
        refresh();
        reset_rsync = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_channel !== '0 || bus.out_last !== 1'b0
            || bus.fifo_read_en !== '0) begin
            n_fail++; $display("FAIL midreset_clear: got valid %b data %h ch%0d last %b en %b, expected all 0",
                               bus.out_valid, bus.out_data, bus.out_channel, bus.out_last, bus.fifo_read_en);
        end
        tick();
        reset_rsync = 1'b0;
        got_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(ew(1, mk(1, 7, i), 1'b0));
        for (int i = 1; i < 4; i++) exp_q.push_back(ew(3, mk(3, 7, i), 1'b0));
        wait_got(5, 40, ok);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL midreset_word: no output, expected ch%0d %h", e.ch, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch !== e.ch || g.data !== e.data || g.last !== e.last) begin
                    n_fail++; $display("FAIL midreset_word: got ch%0d %h last %b, expected ch%0d %h last %b",
                                       g.ch, g.data, g.last, e.ch, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_empty_guard();
        word_t g;
        int    k;
        apply_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 20; i++) begin
                fq[c].push_back(mk(c, 8, i));
                exp_ch[c].push_back(mk(c, 8, i));
            end
        refresh();
        for (int s = 0; s < 300; s++) begin
            force_empty   = NUM_CH'($urandom_range(0, 15));
            bus.ch_enable = NUM_CH'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            refresh();
            #1;
            n_tests++;
            if ((bus.fifo_read_en & bus.fifo_empty) != '0 || !$onehot0(bus.fifo_read_en)
                || (bus.fifo_read_en & ~bus.ch_enable) != '0) begin
                n_fail++; $display("FAIL guard_read_en: en %b empty %b enable %b, expected onehot0 within eligible",
                                   bus.fifo_read_en, bus.fifo_empty, bus.ch_enable);
            end
            tick();
        end
        force_empty   = '0;
        bus.ch_enable = '1;
        bus.out_ready = 1'b1;
        refresh();
        k = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 0 || bus.out_valid === 1'b1) && k < 400) begin
            tick();
            k++;
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            n_tests++;
            if (exp_ch[g.ch].size() == 0) begin
                n_fail++; $display("FAIL guard_order: extra word ch%0d %h, expected none", g.ch, g.data);
            end else if (g.data !== exp_ch[g.ch][0]) begin
                n_fail++; $display("FAIL guard_order: got ch%0d %h, expected %h", g.ch, g.data, exp_ch[g.ch][0]);
                void'(exp_ch[g.ch].pop_front());
            end else begin
                void'(exp_ch[g.ch].pop_front());
            end
        end
        n_tests++;
        if (exp_ch[0].size() + exp_ch[1].size() + exp_ch[2].size() + exp_ch[3].size() != 0) begin
            n_fail++; $display("FAIL guard_drain: %0d words never emitted, expected 0",
                               exp_ch[0].size() + exp_ch[1].size() + exp_ch[2].size() + exp_ch[3].size());
        end
    endtask

    initial begin
        bus.ch_enable      = '1;
        bus.out_ready      = 1'b1;
        bus.fifo_empty     = '1;
        bus.fifo_read_data = '0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_reset_mid_burst();
        test_empty_guard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
